// File: rtl/rpi_byte_to_block.sv
// Receives message bytes from the Pi over a four-phase strobe/ack handshake, packs them into
// 256-bit blocks with CubeHash padding and hands them to the core. Optional MSG_LEN_EN adds msg_len.
module rpi_byte_to_block #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_p,
  input  logic [7:0]   rpi_data,
  input  logic         rpi_strobe,
  input  logic         rpi_last,
  output logic         rpi_ack,
  output logic [255:0] block,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_last,
  output logic         busy
`ifdef MSG_LEN_EN
  ,
  output logic [31:0]  msg_len
`endif
);

  typedef enum logic [1:0] {COLLECT, PAD, HOLD, PAD_BLK} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_strobe_sync;
  logic [7:0]             r_data_p0;
  logic                   r_last_p0;
  logic                   r_ack;
  logic [255:0]           r_block;
  logic                   r_block_last;
  logic [4:0]             r_cnt;
  logic                   r_pad_pending;
  logic                   w_s_strobe;
  logic                   w_capture;
  logic                   w_xfer;
  logic [7:0]             w_idx;

  assign w_s_strobe  = r_strobe_sync[SYNC_STAGES-1];
  assign w_capture   = (r_state == COLLECT) && w_s_strobe && !r_ack;
  assign w_xfer      = (r_state == HOLD) && block_ready;
  assign w_idx       = 8'd255 - {r_cnt, 3'b000};

  assign rpi_ack     = r_ack;
  assign block       = r_block;
  assign block_valid = (r_state == HOLD);
  assign block_last  = r_block_last;
  assign busy        = (r_state != COLLECT) || (r_cnt != 5'd0);

  // Input stage: strobe synchroniser, data/last held stable by the Pi so one flop suffices
  always_ff @(posedge clk) begin
    if (rst_p) r_strobe_sync <= '0;
    else       r_strobe_sync <= {r_strobe_sync[SYNC_STAGES-2:0], rpi_strobe};
  end

  always_ff @(posedge clk) begin
    r_data_p0 <= rpi_data;
    r_last_p0 <= rpi_last;
  end

  always_ff @(posedge clk) begin
    if (rst_p)            r_ack <= 1'b0;
    else if (!w_s_strobe) r_ack <= 1'b0;
    else if (w_capture)   r_ack <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_p) r_state <= COLLECT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: begin
        if (w_capture) begin
          if (r_cnt == 5'd31)  w_state_nxt = HOLD;
          else if (r_last_p0)  w_state_nxt = PAD;
        end
      end
      PAD:     w_state_nxt = HOLD;
      HOLD:    if (w_xfer) w_state_nxt = r_pad_pending ? PAD_BLK : COLLECT;
      PAD_BLK: w_state_nxt = HOLD;
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Block buffer: cnt already points one past the last byte when PAD runs
  always_ff @(posedge clk) begin
    if (rst_p) begin
      r_block       <= '0;
      r_block_last  <= 1'b0;
      r_cnt         <= '0;
      r_pad_pending <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_capture) begin
            r_block[w_idx -: 8] <= r_data_p0;
            r_cnt               <= r_cnt + 5'd1;
            if (r_last_p0 && (r_cnt == 5'd31)) r_pad_pending <= 1'b1;
          end
        end
        PAD: begin
          r_block[w_idx -: 8] <= 8'h80;
          r_block_last        <= 1'b1;
        end
        HOLD: begin
          if (block_ready) begin
            r_block      <= '0;
            r_cnt        <= '0;
            r_block_last <= 1'b0;
          end
        end
        PAD_BLK: begin
          r_block[255:248] <= 8'h80;
          r_pad_pending    <= 1'b0;
          r_block_last     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MSG_LEN_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_msg_len;
  assign msg_len = r_msg_len;

  always_ff @(posedge clk) begin
    if (rst_p)                      r_msg_len <= '0;
    else if (w_xfer && r_block_last) r_msg_len <= '0;
    else if (w_capture)             r_msg_len <= sat_inc(r_msg_len);
  end
`endif

endmodule

// File: tb/tb_rpi_byte_to_block.sv
// Randomised bench for rpi_byte_to_block: a padding model fills an expected-block queue that a
// monitor drains whenever the DUT presents a block.
module tb_rpi_byte_to_block;

  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst_p;
  logic [7:0]   rpi_data;
  logic         rpi_strobe;
  logic         rpi_last;
  logic         rpi_ack;
  logic [255:0] block;
  logic         block_valid;
  logic         block_ready;
  logic         block_last;
  logic         busy;
`ifdef MSG_LEN_EN
  logic [31:0]  msg_len;
`endif

  rpi_byte_to_block #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_p(rst_p), .rpi_data(rpi_data), .rpi_strobe(rpi_strobe),
    .rpi_last(rpi_last), .rpi_ack(rpi_ack), .block(block), .block_valid(block_valid),
    .block_ready(block_ready), .block_last(block_last), .busy(busy)
`ifdef MSG_LEN_EN
    , .msg_len(msg_len)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] blk;
    logic         last;
    logic [31:0]  len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   ack_rise_cyc = 0;
  int   valid_rise_cyc = 0;
  int   ack_rise_cnt = 0;
  bit   rdy_rand  = 1'b0;
  bit   rdy_force = 1'b1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %0h want %0h", name, act, exp);
  endtask

  // Reference: message || 0x80 || zeros up to a multiple of 32 bytes, last flag on the final block
  task automatic push_msg(input logic [7:0] msg[$]);
    logic [7:0]   padded[$];
    logic [255:0] blk;
    int           nblk;
    exp_t         e;
    padded = msg;
    padded.push_back(8'h80);
    while (padded.size() % 32 != 0) padded.push_back(8'h00);
    nblk = padded.size() / 32;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int k = 0; k < 32; k++) blk = {blk[247:0], padded[b*32 + k]};
      e.blk  = blk;
      e.last = (b == nblk - 1);
      e.len  = 32'(msg.size());
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_ack(input logic lvl, input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rpi_ack !== lvl && n < budget);
    if (rpi_ack !== lvl) begin
      n_checks++;
      $display("FAIL ack_timeout got %b want %b after %0d cycles", rpi_ack, lvl, n);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input int hold);
    int n;
    @(posedge clk); #1;
    rpi_data = d;
    rpi_last = l;
    @(posedge clk); #1;
    rpi_strobe = 1'b1;
    wait_ack(1'b1, 3000, n);
    repeat (hold) begin @(posedge clk); #1; end
    chk("ack_held", 256'(rpi_ack), 256'(1));
    rpi_strobe = 1'b0;
    wait_ack(1'b0, 20, n);
    chk("ack_fall_latency", 256'(n), 256'(SYNC + 1));
    rpi_last = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] msg[$]);
    push_msg(msg);
    for (int i = 0; i < msg.size(); i++)
      send_byte(msg[i], i == msg.size() - 1, $urandom_range(0, 3));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(posedge clk); #1; n++; end
    chk("drain_remaining", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic monitor();
    bit prev_ack = 1'b0;
    bit prev_vld = 1'b0;
    bit clr_pend = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rpi_ack && !prev_ack) begin ack_rise_cyc = cyc; ack_rise_cnt++; end
      if (block_valid && !prev_vld) valid_rise_cyc = cyc;
      prev_ack = rpi_ack;
      prev_vld = block_valid;
`ifdef MSG_LEN_EN
      if (clr_pend) begin
        chk("msg_len_cleared", 256'(msg_len), 256'(0));
        clr_pend = 1'b0;
      end
`endif
      if (block_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_block got %0h want none", block);
        end else begin
          chk("block", block, exp_q[0].blk);
          chk("block_last", 256'(block_last), 256'(exp_q[0].last));
`ifdef MSG_LEN_EN
          if (exp_q[0].last) chk("msg_len", 256'(msg_len), 256'(exp_q[0].len));
`endif
          if (block_ready === 1'b1) begin
            clr_pend = exp_q[0].last;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk); #1;
      block_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ack"},   256'(rpi_ack), 256'(0));
    chk({tag, "_block"}, block, 256'(0));
    chk({tag, "_valid"}, 256'(block_valid), 256'(0));
    chk({tag, "_last"},  256'(block_last), 256'(0));
    chk({tag, "_busy"},  256'(busy), 256'(0));
`ifdef MSG_LEN_EN
    chk({tag, "_msg_len"}, 256'(msg_len), 256'(0));
`endif
  endtask

  initial begin
    logic [7:0] msg[$];
    int         ack_seen;
    int         rises;
    int         n;
    rst_p = 1'b1; rpi_data = 8'h00; rpi_strobe = 1'b0; rpi_last = 1'b0; block_ready = 1'b1;
    fork
      monitor();
      ready_driver();
    join_none
    repeat (3) @(posedge clk);
    #1 rst_p = 1'b0;
    check_idle("reset");

    // 32 bytes 0x00..0x1F: full block, then a pure padding block
    msg = {};
    for (int i = 0; i < 32; i++) msg.push_back(8'(i));
    send_msg(msg);
    drain();

    // 3-byte message; valid rises one cycle after ack (two after capture)
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    msg = {8'hAA, 8'hBB, 8'hCC};
    send_msg(msg);
    chk("valid_after_ack", 256'(valid_rise_cyc - ack_rise_cyc), 256'(1));
    rdy_force = 1'b1;
    drain();

    // 33-byte message with the first block stalled for 50 cycles
    rdy_force = 1'b0;
    msg = {};
    for (int i = 0; i < 33; i++) msg.push_back(8'($urandom_range(0, 255)));
    push_msg(msg);
    for (int i = 0; i < 32; i++) send_byte(msg[i], 1'b0, 0);
    @(posedge clk); #1;
    rpi_data = msg[32]; rpi_last = 1'b1;
    @(posedge clk); #1;
    rpi_strobe = 1'b1;
    ack_seen = 0;
    repeat (50) begin @(posedge clk); #1; if (rpi_ack) ack_seen = 1; end
    chk("stall_no_ack", 256'(ack_seen), 256'(0));
    chk("stall_valid", 256'(block_valid), 256'(1));
    rdy_force = 1'b1;
    wait_ack(1'b1, 200, n);
    rpi_strobe = 1'b0;
    wait_ack(1'b0, 20, n);
    rpi_last = 1'b0;
    drain();

    // Strobe held for 200 cycles gives exactly one capture
    rises = ack_rise_cnt;
    push_msg('{8'h11, 8'h22});
    send_byte(8'h11, 1'b0, 200);
    chk("long_strobe_one_ack", 256'(ack_rise_cnt - rises), 256'(1));
    send_byte(8'h22, 1'b1, 0);
    drain();

    // Reset mid-message discards 10 captured bytes
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 0);
    chk("busy_partial", 256'(busy), 256'(1));
    @(posedge clk); #1 rst_p = 1'b1;
    @(posedge clk); #1 rst_p = 1'b0;
    check_idle("midreset");
    send_msg('{8'h55});
    drain();

    // Random messages with random back-pressure, then a 40-byte message
    rdy_rand = 1'b1;
    for (int m = 0; m < 6; m++) begin
      msg = {};
      n = $urandom_range(1, 70);
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
      send_msg(msg);
    end
    msg = {};
    for (int i = 0; i < 40; i++) msg.push_back(8'($urandom_range(0, 255)));
    send_msg(msg);
    drain();
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_idle("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
